// File: rtl/bcd_to_binary_converter_if.sv
// Handshake and data bundle between a BCD source and bcd_to_binary_converter.
// master drives start/bcd_number; slave (the converter) returns the result and status.
interface bcd_to_binary_converter_if #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_WIDTH  = 20
);
  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_number;
  logic [BIN_WIDTH-1:0]    bin_number;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, bcd_number,
    input  bin_number, busy, done, err
  );

  modport slave (
    input  start, bcd_number,
    output bin_number, busy, done, err
  );
endinterface

// File: rtl/bcd_to_binary_converter.sv
// Reverse double-dabble BCD-to-binary converter, one shift step per clock.
// Optional feature macro: BCD_RANGE_CHECK_EN (reject inputs with a digit > 9 and flag err).
module bcd_to_binary_converter #(
  parameter int NUM_DIGITS = 6,
  parameter int BIN_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  bcd_to_binary_converter_if.slave     bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t               r_state, w_state_next;
  logic [BCD_W-1:0]     r_bcd, w_bcd_next, w_bcd_step;
  logic [BIN_WIDTH-1:0] r_bin, w_bin_next, w_bin_step;
  logic [BIN_WIDTH-1:0] r_bin_number, w_bin_number_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 w_skip;

  // One step: shift {bcd, bin} right, then pull every digit >= 8 back by 3.
  always_comb begin
    {w_bcd_step, w_bin_step} = {r_bcd, r_bin} >> 1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_bcd_step[4*d+3]) begin
        w_bcd_step[4*d +: 4] = w_bcd_step[4*d +: 4] - 4'd3;
      end
    end
  end

  // NOTE: every signal gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_next      = r_state;
    w_bcd_next        = r_bcd;
    w_bin_next        = r_bin;
    w_cnt_next        = r_cnt;
    w_bin_number_next = r_bin_number;
    w_busy_next       = r_busy;
    w_done_next       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_bcd_next   = bus.bcd_number;
          w_bin_next   = '0;
          w_cnt_next   = '0;
          w_busy_next  = 1'b1;
          w_state_next = S_CONVERT;
        end
      end

      S_CONVERT: begin
        if (w_skip) begin
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_bcd_next = w_bcd_step;
          w_bin_next = w_bin_step;
          w_cnt_next = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_STEP) begin
            w_bin_number_next = w_bin_step;
            w_done_next       = 1'b1;
            w_state_next      = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_cnt        <= '0;
      r_bin_number <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bcd        <= w_bcd_next;
      r_bin        <= w_bin_next;
      r_cnt        <= w_cnt_next;
      r_bin_number <= w_bin_number_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  logic w_in_invalid;
  logic r_range_err;
  logic r_err;

  always_comb begin
    w_in_invalid = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bus.bcd_number[4*d +: 4] > 4'd9) begin
        w_in_invalid = 1'b1;
      end
    end
  end

  // The load-time verdict decides both the skip and the err value reported with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_range_err <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_range_err <= w_in_invalid;
      end
      if (w_done_next) begin
        r_err <= r_range_err;
      end
    end
  end

  assign w_skip  = r_range_err;
  assign bus.err = r_err;
`else
  assign w_skip  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.bin_number = r_bin_number;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Scoreboard bench for bcd_to_binary_converter: stimulus queues expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_to_binary_converter;
  localparam int ND    = 6;
  localparam int BW    = 20;
  localparam int BCD_W = 4 * ND;

  logic clk = 1'b0;
  logic reset;

  bcd_to_binary_converter_if #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) bus ();

  bcd_to_binary_converter #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] bin;
    logic          err;
    logic          chk_bin;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk_bin) check("bin_number", 32'(bus.bin_number), 32'(e.bin));
        check("err", 32'(bus.err), 32'(e.err));
        check("done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic launch(input logic [BCD_W-1:0] bcd, output int c0);
    @(negedge clk);
    bus.bcd_number = bcd;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    c0        = cyc;
    bus.start = 1'b0;
    check("busy_after_load", 32'(bus.busy), 32'd1);
  endtask

  task automatic expect_result(input logic [BW-1:0] bin, input logic err,
                               input logic chk_bin, input int due);
    exp_t e;
    e.bin     = bin;
    e.err     = err;
    e.chk_bin = chk_bin;
    e.due     = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.bcd_number = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bin", 32'(bus.bin_number), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    // All-zero input.
    launch(24'h000000, c0);
    expect_result(20'h00000, 1'b0, 1'b1, c0 + 20);
    drain();

    // Maximum value.
    launch(24'h999999, c0);
    expect_result(20'hF423F, 1'b0, 1'b1, c0 + 20);
    drain();

    // Input captured at load; start while busy ignored.
    launch(24'h123456, c0);
    expect_result(20'h1E240, 1'b0, 1'b1, c0 + 20);
    repeat (4) @(negedge clk);
    bus.bcd_number = 24'h000001;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_mid_convert", 32'(bus.busy), 32'd1);
    drain();
    repeat (30) @(negedge clk);
    check("no_queued_start", 32'(bus.busy), 32'd0);

    // start held high: back-to-back conversions, second load at E22.
    @(negedge clk);
    bus.bcd_number = 24'h000250;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    c0             = cyc;
    bus.bcd_number = 24'h000999;
    expect_result(20'h000FA, 1'b0, 1'b1, c0 + 20);
    expect_result(20'h003E7, 1'b0, 1'b1, c0 + 42);
    repeat (23) @(negedge clk);
    bus.start = 1'b0;
    check("busy_second_conv", 32'(bus.busy), 32'd1);
    drain();

    // Invalid digit after a known result of 0xFA.
    launch(24'h000250, c0);
    expect_result(20'h000FA, 1'b0, 1'b1, c0 + 20);
    drain();
    launch(24'h0000A5, c0);
`ifdef BCD_RANGE_CHECK_EN
    expect_result(20'h000FA, 1'b1, 1'b1, c0 + 1);
`else
    expect_result(20'h00000, 1'b0, 1'b0, c0 + 20);
`endif
    drain();

    // Reset in the middle of a conversion.
    launch(24'h999999, c0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bin", 32'(bus.bin_number), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_idle", 32'(bus.busy), 32'd0);

    launch(24'h000042, c0);
    expect_result(20'h0002A, 1'b0, 1'b1, c0 + 20);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
